timestamp_hdr_inserter: RTL and testbench
=========================================

# timestamp_hdr_inserter

Inserts one 64-bit arrival-timestamp module header into every packet on the user data path. It sits between the input arbiter and the NIC output port lookup. The stamp is taken when the packet's first word enters the block. The inserted word goes after the packet's existing module headers and ahead of the first payload word (ctrl==0), where downstream stages read it.

## Interface
- DATA_WIDTH, 64, data bus width; must be 64 so a single word carries the stamp
- CTRL_WIDTH, DATA_WIDTH/8, ctrl bus width
- UDP_REG_SRC_WIDTH, 2, register source tag width
- TS_CTRL, 8'h10, ctrl value of the inserted timestamp word; must be nonzero and differ from IO_QUEUE_STAGE_NUM
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- in_data  in  DATA_WIDTH  upstream data
- in_ctrl  in  CTRL_WIDTH  upstream ctrl
- in_wr  in  1  upstream word strobe
- in_rdy  out  1  block can accept a word
- out_data  out  DATA_WIDTH  downstream data
- out_ctrl  out  CTRL_WIDTH  downstream ctrl
- out_wr  out  1  downstream word strobe
- out_rdy  in  1  downstream can accept a word
- timestamp  in  64  free-running time counter
- timestamp_valid  in  1  timestamp counter is synchronised
- reg_req_in, reg_ack_in, reg_rd_wr_L_in, reg_addr_in[`UDP_REG_ADDR_WIDTH], reg_data_in[`CPCI_NF2_DATA_WIDTH], reg_src_in[UDP_REG_SRC_WIDTH]  in  register ring input
- reg_*_out  out  same widths  register ring output, delayed one cycle

## Operation
- Input side:
  - Words enter a 4-deep small_fifo holding {ctrl,data}.
  - in_rdy = !nearly_full.
- Input tracker FSM:
  - States: IN_IDLE and IN_PKT.
  - IN_IDLE -> IN_PKT on any in_wr. On that same cycle, timestamp is pushed into a 2-entry stamp queue.
  - IN_PKT -> IN_IDLE on an in_wr whose ctrl is nonzero and which follows at least one ctrl==0 word (end-of-packet word).
- Output FSM:
  - OUT_HDRS: head words with ctrl!=0 are popped and forwarded unchanged.
    - When the head word has ctrl==0, emit {TS_CTRL, stamp-queue head} instead of popping it.
    - Then pop the stamp queue and go to OUT_INSERTED.
  - OUT_INSERTED: forward words unchanged. Go to OUT_PAYLOAD on the first forwarded ctrl==0 word.
  - OUT_PAYLOAD: forward words unchanged. Return to OUT_HDRS after forwarding a word with ctrl!=0.
- A packet with no module headers (first word ctrl==0) still receives the timestamp word, placed first.
- Module headers are not counted in the IOQ word/byte length fields, so those fields are not modified.
- Stamp queue:
  - Its depth of 2 covers the worst case of two packet starts resident in the FIFO.
  - If it is full, in_rdy is forced low.
- Register ring: pure pass-through; every signal registered once.

## Timing
- Outputs are registered. A word is issued only on a cycle where out_rdy=1 and a word (FIFO head or pending insert) is available. out_wr pulses exactly one cycle per word.
- Latency: a word written at cycle N appears on out_wr no earlier than N+2.
- Each insertion adds one output cycle, in place of one pop.
- Stamp sampling: the value of timestamp on the cycle in_wr accepts the packet's first word.
- Back-pressure:
  - out_rdy low freezes both the FIFO and the FSM.
  - The insertion decision holds across stalls.
  - The pending insert is never duplicated or dropped.
- Simultaneous FIFO write and read of the same packet's first word: the stamp is pushed before it is needed, so the queue is never read empty.
- Reset (asynchronous, may be asserted mid-packet):
  - out_wr=0, out_data=0, out_ctrl=0.
  - FIFO and stamp queue emptied.
  - Both FSMs go to their idle/OUT_HDRS state.
  - All reg_*_out=0.
  - Partial packets are discarded.

## Configuration
- TS_HDR_VALID_GATE_EN defined:
  - timestamp_valid is sampled together with the stamp and stored alongside it.
  - Packets whose stored valid bit is 0 pass through with no timestamp word.
- Undefined: every packet gets a timestamp word, and timestamp_valid is ignored.

## Structure
- Shared package constants: TS_CTRL default, the FSM state encodings, and the stamp-queue depth.
- One sub-module, ts_stamp_queue: a 2-entry FIFO with 65-bit entries (stamp plus valid bit), exposing push, pop, head, full and empty. The data FIFO reuses small_fifo.

## Test plan
- Header + 3 payload words (ctrl 0xFF, 0, 0, 0x01), timestamp=0x1234 at first word -> output ctrl 0xFF, 0x10 (data 0x1234), 0, 0, 0x01.
- Payload-only packet (ctrl 0, 0x80), timestamp=0xA -> output ctrl 0x10 (0xA), 0, 0x80.
- Two back-to-back 3-word packets stamped 100 and 104, with out_rdy held low for 10 cycles -> both inserts are correct, in_rdy deasserts, and no word is lost.
- out_rdy toggled every cycle during an insert -> the timestamp word is issued exactly once.
- Reset asserted mid-payload, then a fresh packet -> out_wr=0 during reset; the new packet gets the stamp sampled after reset.
- With TS_HDR_VALID_GATE_EN defined and timestamp_valid=0 -> packet unchanged; with timestamp_valid=1 -> header inserted.

Source files
------------

// File: rtl/timestamp_hdr_inserter_pkg.sv
// Shared constants, FSM encodings and stamp-queue entry type for timestamp_hdr_inserter.
// Default register-ring widths are provided here when the platform headers do not define them.
`ifndef UDP_REG_ADDR_WIDTH
  `define UDP_REG_ADDR_WIDTH 23
`endif
`ifndef CPCI_NF2_DATA_WIDTH
  `define CPCI_NF2_DATA_WIDTH 32
`endif

package timestamp_hdr_inserter_pkg;

  localparam logic [7:0] TS_CTRL_DEFAULT = 8'h10;
  localparam int         STAMP_Q_DEPTH   = 2;

  typedef enum logic {
    IN_IDLE,
    IN_PKT
  } in_state_e;

  typedef enum logic [1:0] {
    OUT_HDRS,
    OUT_INSERTED,
    OUT_PAYLOAD
  } out_state_e;

  typedef struct packed {
    logic        valid;
    logic [63:0] stamp;
  } stamp_entry_t;

endpackage

// File: rtl/small_fifo.sv
// Small first-word-fall-through FIFO: dout shows the head entry whenever empty is low.
module small_fifo #(
  parameter int WIDTH          = 72,
  parameter int MAX_DEPTH_BITS = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             nearly_full,
  output logic             empty
);

  localparam int DEPTH = 2 ** MAX_DEPTH_BITS;
  localparam int CW    = MAX_DEPTH_BITS + 1;

  logic [WIDTH-1:0]          mem_q [DEPTH];
  logic [MAX_DEPTH_BITS-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]             count_q;
  logic                      wr_ok, rd_ok;

  assign wr_ok       = wr_en && !full;
  assign rd_ok       = rd_en && !empty;
  assign full        = (count_q == CW'(DEPTH));
  assign nearly_full = (count_q >= CW'(DEPTH - 1));
  assign empty       = (count_q == '0);
  assign dout        = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + MAX_DEPTH_BITS'(1);
      if (rd_ok) rd_ptr_q <= rd_ptr_q + MAX_DEPTH_BITS'(1);
      count_q <= count_q + CW'(wr_ok) - CW'(rd_ok);
    end
  end

endmodule

// File: rtl/ts_stamp_queue.sv
// Two-entry FIFO of arrival stamps (64-bit stamp plus valid bit), one entry per
// packet start that has entered the data FIFO but not yet received its insert.
module ts_stamp_queue
  import timestamp_hdr_inserter_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  stamp_entry_t din_i,
  input  logic         pop_i,
  output stamp_entry_t head_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int PW = $clog2(STAMP_Q_DEPTH);
  localparam int CW = $clog2(STAMP_Q_DEPTH + 1);

  stamp_entry_t    mem_q [STAMP_Q_DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            push_ok, pop_ok;

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign full_o  = (count_q == CW'(STAMP_Q_DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  // NOTE: storage is left unreset; the pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din_i;
  end

  // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/timestamp_hdr_inserter.sv
// Inserts a 64-bit arrival-timestamp module header ahead of each packet's first payload word.
// Build option TS_HDR_VALID_GATE_EN: only packets stamped while timestamp_valid=1 get the header.
module timestamp_hdr_inserter
  import timestamp_hdr_inserter_pkg::*;
#(
  parameter int                    DATA_WIDTH        = 64,
  parameter int                    CTRL_WIDTH        = DATA_WIDTH / 8,
  parameter int                    UDP_REG_SRC_WIDTH = 2,
  parameter logic [CTRL_WIDTH-1:0] TS_CTRL           = TS_CTRL_DEFAULT
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [DATA_WIDTH-1:0]            in_data,
  input  logic [CTRL_WIDTH-1:0]            in_ctrl,
  input  logic                             in_wr,
  output logic                             in_rdy,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic [CTRL_WIDTH-1:0]            out_ctrl,
  output logic                             out_wr,
  input  logic                             out_rdy,
  input  logic [63:0]                      timestamp,
  input  logic                             timestamp_valid,
  input  logic                             reg_req_in,
  input  logic                             reg_ack_in,
  input  logic                             reg_rd_wr_L_in,
  input  logic [`UDP_REG_ADDR_WIDTH-1:0]   reg_addr_in,
  input  logic [`CPCI_NF2_DATA_WIDTH-1:0]  reg_data_in,
  input  logic [UDP_REG_SRC_WIDTH-1:0]     reg_src_in,
  output logic                             reg_req_out,
  output logic                             reg_ack_out,
  output logic                             reg_rd_wr_L_out,
  output logic [`UDP_REG_ADDR_WIDTH-1:0]   reg_addr_out,
  output logic [`CPCI_NF2_DATA_WIDTH-1:0]  reg_data_out,
  output logic [UDP_REG_SRC_WIDTH-1:0]     reg_src_out
);

  logic [CTRL_WIDTH-1:0] head_ctrl;
  logic [DATA_WIDTH-1:0] head_data;
  logic fifo_rd, fifo_empty, fifo_nearly_full, fifo_full_unused;
  logic in_accept;
  stamp_entry_t sq_din, sq_head;
  logic sq_push, sq_pop, sq_full, sq_empty;

  small_fifo #(.WIDTH(CTRL_WIDTH + DATA_WIDTH), .MAX_DEPTH_BITS(2)) u_data_fifo (
    .clk        (clk),
    .reset      (reset),
    .din        ({in_ctrl, in_data}),
    .wr_en      (in_accept),
    .rd_en      (fifo_rd),
    .dout       ({head_ctrl, head_data}),
    .full       (fifo_full_unused),
    .nearly_full(fifo_nearly_full),
    .empty      (fifo_empty)
  );

  ts_stamp_queue u_stamp_q (
    .clk    (clk),
    .reset  (reset),
    .push_i (sq_push),
    .din_i  (sq_din),
    .pop_i  (sq_pop),
    .head_o (sq_head),
    .full_o (sq_full),
    .empty_o(sq_empty)
  );

  assign in_rdy    = !fifo_nearly_full && !sq_full;
  assign in_accept = in_wr && in_rdy;

`ifdef TS_HDR_VALID_GATE_EN
  assign sq_din = '{valid: timestamp_valid, stamp: timestamp};
`else
  logic ts_valid_unused;
  assign ts_valid_unused = timestamp_valid;
  assign sq_din = '{valid: 1'b1, stamp: timestamp};
`endif

  // Input tracker: marks packet starts so each one pushes exactly one stamp.
  in_state_e in_state_q, in_state_d;
  logic      seen_payload_q, seen_payload_d;

  // NOTE: every always_comb output gets its default first, so no path can infer a latch.
  always_comb begin
    in_state_d     = in_state_q;
    seen_payload_d = seen_payload_q;
    sq_push        = 1'b0;
    if (in_accept) begin
      case (in_state_q)
        IN_IDLE: begin
          sq_push        = 1'b1;
          in_state_d     = IN_PKT;
          seen_payload_d = (in_ctrl == '0);
        end
        IN_PKT: begin
          if (in_ctrl == '0)     seen_payload_d = 1'b1;
          else if (seen_payload_q) in_state_d   = IN_IDLE;
        end
        default: in_state_d = IN_IDLE;
      endcase
    end
  end

  out_state_e            out_state_q, out_state_d;
  logic                  out_wr_q, out_wr_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [CTRL_WIDTH-1:0] out_ctrl_q, out_ctrl_d;

  always_comb begin
    out_state_d = out_state_q;
    out_wr_d    = 1'b0;
    out_data_d  = out_data_q;
    out_ctrl_d  = out_ctrl_q;
    fifo_rd     = 1'b0;
    sq_pop      = 1'b0;
    if (out_rdy && !fifo_empty) begin
      case (out_state_q)
        OUT_HDRS: begin
          if (head_ctrl != '0) begin
            fifo_rd = 1'b1; out_wr_d = 1'b1;
            out_ctrl_d = head_ctrl; out_data_d = head_data;
          end else if (!sq_empty) begin
            sq_pop = 1'b1;
            out_wr_d = 1'b1;
            if (sq_head.valid) begin
              // The payload word stays at the FIFO head and is forwarded next.
              out_ctrl_d  = TS_CTRL;
              out_data_d  = DATA_WIDTH'(sq_head.stamp);
              out_state_d = OUT_INSERTED;
            end else begin
              fifo_rd = 1'b1;
              out_ctrl_d  = head_ctrl;
              out_data_d  = head_data;
              out_state_d = OUT_PAYLOAD;
            end
          end
        end
        OUT_INSERTED: begin
          fifo_rd = 1'b1; out_wr_d = 1'b1;
          out_ctrl_d = head_ctrl; out_data_d = head_data;
          if (head_ctrl == '0) out_state_d = OUT_PAYLOAD;
        end
        OUT_PAYLOAD: begin
          fifo_rd = 1'b1; out_wr_d = 1'b1;
          out_ctrl_d = head_ctrl; out_data_d = head_data;
          if (head_ctrl != '0) out_state_d = OUT_HDRS;
        end
        default: out_state_d = OUT_HDRS;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_state_q     <= IN_IDLE;
      seen_payload_q <= 1'b0;
      out_state_q    <= OUT_HDRS;
      out_wr_q       <= 1'b0;
      out_data_q     <= '0;
      out_ctrl_q     <= '0;
    end else begin
      in_state_q     <= in_state_d;
      seen_payload_q <= seen_payload_d;
      out_state_q    <= out_state_d;
      out_wr_q       <= out_wr_d;
      out_data_q     <= out_data_d;
      out_ctrl_q     <= out_ctrl_d;
    end
  end

  assign out_wr   = out_wr_q;
  assign out_data = out_data_q;
  assign out_ctrl = out_ctrl_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_req_out     <= 1'b0;
      reg_ack_out     <= 1'b0;
      reg_rd_wr_L_out <= 1'b0;
      reg_addr_out    <= '0;
      reg_data_out    <= '0;
      reg_src_out     <= '0;
    end else begin
      reg_req_out     <= reg_req_in;
      reg_ack_out     <= reg_ack_in;
      reg_rd_wr_L_out <= reg_rd_wr_L_in;
      reg_addr_out    <= reg_addr_in;
      reg_data_out    <= reg_data_in;
      reg_src_out     <= reg_src_in;
    end
  end

endmodule

// File: tb/tb_timestamp_hdr_inserter.sv
// Directed bench for timestamp_hdr_inserter with an expected-word scoreboard.
`ifndef UDP_REG_ADDR_WIDTH
  `define UDP_REG_ADDR_WIDTH 23
`endif
`ifndef CPCI_NF2_DATA_WIDTH
  `define CPCI_NF2_DATA_WIDTH 32
`endif

module tb_timestamp_hdr_inserter;

  localparam logic [7:0] TS_CTRL = 8'h10;
`ifdef TS_HDR_VALID_GATE_EN
  localparam bit GATE = 1'b1;
`else
  localparam bit GATE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] in_data;
  logic [7:0]  in_ctrl;
  logic        in_wr, in_rdy;
  logic [63:0] out_data;
  logic [7:0]  out_ctrl;
  logic        out_wr, out_rdy;
  logic [63:0] timestamp;
  logic        timestamp_valid;
  logic        reg_req_in, reg_ack_in, reg_rd_wr_L_in;
  logic [`UDP_REG_ADDR_WIDTH-1:0]  reg_addr_in, reg_addr_out;
  logic [`CPCI_NF2_DATA_WIDTH-1:0] reg_data_in, reg_data_out;
  logic [1:0]  reg_src_in, reg_src_out;
  logic        reg_req_out, reg_ack_out, reg_rd_wr_L_out;

  timestamp_hdr_inserter dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr), .in_rdy(in_rdy),
    .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr), .out_rdy(out_rdy),
    .timestamp(timestamp), .timestamp_valid(timestamp_valid),
    .reg_req_in(reg_req_in), .reg_ack_in(reg_ack_in), .reg_rd_wr_L_in(reg_rd_wr_L_in),
    .reg_addr_in(reg_addr_in), .reg_data_in(reg_data_in), .reg_src_in(reg_src_in),
    .reg_req_out(reg_req_out), .reg_ack_out(reg_ack_out), .reg_rd_wr_L_out(reg_rd_wr_L_out),
    .reg_addr_out(reg_addr_out), .reg_data_out(reg_data_out), .reg_src_out(reg_src_out)
  );

  always #5 clk = ~clk;

  logic [71:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0]  pkt_c[8];
  logic [63:0] pkt_d[8];

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0 && out_wr === 1'b1) begin
      if (exp_q.size() == 0) check("spurious_out_wr", out_wr, 1'b0);
      else                   check("out_word", {out_ctrl, out_data}, exp_q.pop_front());
    end
  end

  task automatic load(input int i, input logic [7:0] c, input logic [63:0] d);
    pkt_c[i] = c;
    pkt_d[i] = d;
  endtask

  task automatic send_word(input logic [7:0] c, input logic [63:0] d,
                           input logic [63:0] ts, input logic tv);
    int n = 0;
    @(negedge clk);
    while (in_rdy !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) check("in_rdy_timeout", in_rdy, 1'b1);
    in_ctrl = c; in_data = d; timestamp = ts; timestamp_valid = tv; in_wr = 1'b1;
    @(posedge clk);
    #1;
    in_wr = 1'b0;
    timestamp = ~ts;
    timestamp_valid = ~tv;
  endtask

  // Reference: the stamp word goes right before the first ctrl==0 word.
  task automatic send_pkt(input int n, input logic [63:0] stamp, input logic tv);
    bit ins  = GATE ? tv : 1'b1;
    bit done = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (!done && pkt_c[i] == 8'h00) begin
        if (ins) exp_q.push_back({TS_CTRL, stamp});
        done = 1'b1;
      end
      exp_q.push_back({pkt_c[i], pkt_d[i]});
    end
    for (int i = 0; i < n; i++)
      send_word(pkt_c[i], pkt_d[i], (i == 0) ? stamp : stamp + 64'h5555, (i == 0) ? tv : ~tv);
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    check(tag, exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; in_wr = 1'b0; in_ctrl = '0; in_data = '0;
    out_rdy = 1'b1; timestamp = '0; timestamp_valid = 1'b0;
    reg_req_in = 1'b0; reg_ack_in = 1'b0; reg_rd_wr_L_in = 1'b0;
    reg_addr_in = '0; reg_data_in = '0; reg_src_in = '0;
    repeat (3) @(negedge clk);
    check("rst_out_wr", out_wr, 1'b0);
    check("rst_out_data", out_data, 64'h0);
    check("rst_out_ctrl", out_ctrl, 8'h0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_in_rdy", in_rdy, 1'b1);

    // Header + 3 payload words.
    load(0, 8'hFF, 64'hAAAA_0001); load(1, 8'h00, 64'h1111);
    load(2, 8'h00, 64'h2222);      load(3, 8'h01, 64'h3333);
    send_pkt(4, 64'h1234, 1'b1);
    wait_drain("t1_drain");

    // Payload-only packet: stamp word comes first.
    load(0, 8'h00, 64'h5050); load(1, 8'h80, 64'h6060);
    send_pkt(2, 64'hA, 1'b1);
    wait_drain("t2_drain");

    // Two back-to-back packets under a 10-cycle output stall.
    out_rdy = 1'b0;
    fork
      begin
        load(0, 8'hFF, 64'hB001); load(1, 8'h00, 64'hB002); load(2, 8'h01, 64'hB003);
        send_pkt(3, 64'd100, 1'b1);
        load(0, 8'hFF, 64'hC001); load(1, 8'h00, 64'hC002); load(2, 8'h01, 64'hC003);
        send_pkt(3, 64'd104, 1'b1);
      end
      begin
        repeat (10) @(negedge clk);
        check("t3_in_rdy_low", in_rdy, 1'b0);
        out_rdy = 1'b1;
      end
    join
    wait_drain("t3_drain");

    // out_rdy toggling across the insert.
    out_rdy = 1'b0;
    load(0, 8'hFF, 64'hD001); load(1, 8'h00, 64'hD002);
    load(2, 8'h00, 64'hD003); load(3, 8'h01, 64'hD004);
    fork
      send_pkt(4, 64'h4444, 1'b1);
      begin
        repeat (20) begin
          @(negedge clk);
          out_rdy = ~out_rdy;
        end
        out_rdy = 1'b1;
      end
    join
    wait_drain("t4_drain");

    // Register ring: one-cycle pass-through.
    @(negedge clk);
    reg_req_in = 1'b1; reg_ack_in = 1'b1; reg_rd_wr_L_in = 1'b1;
    reg_addr_in = 23'h12345; reg_data_in = 32'hCAFE_BABE; reg_src_in = 2'd2;
    @(negedge clk);
    check("reg_req", reg_req_out, 1'b1);
    check("reg_ack", reg_ack_out, 1'b1);
    check("reg_rd_wr_L", reg_rd_wr_L_out, 1'b1);
    check("reg_addr", reg_addr_out, 23'h12345);
    check("reg_data", reg_data_out, 32'hCAFE_BABE);
    check("reg_src", reg_src_out, 2'd2);

    // Reset in the middle of a packet, then a fresh packet.
    out_rdy = 1'b0;
    send_word(8'hFF, 64'hE001, 64'h50, 1'b1);
    send_word(8'h00, 64'hE002, 64'h51, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_out_wr", out_wr, 1'b0);
    check("midrst_reg_req", reg_req_out, 1'b0);
    check("midrst_reg_data", reg_data_out, 32'h0);
    out_rdy = 1'b1;
    reg_req_in = 1'b0; reg_ack_in = 1'b0; reg_rd_wr_L_in = 1'b0;
    reg_addr_in = '0; reg_data_in = '0; reg_src_in = '0;
    repeat (3) begin
      @(negedge clk);
      check("midrst_hold_out_wr", out_wr, 1'b0);
    end
    check("midrst_out_ctrl", out_ctrl, 8'h0);
    reset = 1'b0;
    load(0, 8'hFF, 64'hF001); load(1, 8'h00, 64'hF002); load(2, 8'h01, 64'hF003);
    send_pkt(3, 64'h77, 1'b1);
    wait_drain("t5_drain");

    // timestamp_valid low then high.
    load(0, 8'hFF, 64'h9001); load(1, 8'h00, 64'h9002); load(2, 8'h01, 64'h9003);
    send_pkt(3, 64'h88, 1'b0);
    load(0, 8'hFF, 64'h9101); load(1, 8'h00, 64'h9102); load(2, 8'h01, 64'h9103);
    send_pkt(3, 64'h99, 1'b1);
    wait_drain("t6_drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
